control_sequencer: RTL and testbench

- Parametrised successor to the single-cycle instruction decoder.
- Accepts instructions over a valid/ready handshake into an internal FIFO of DEPTH entries.
- Issues one instruction at a time as registered control strobes and fields to the systolic array, bias, activation and weight-FIFO datapath.
- Supports per-instruction repeat counts, stall and flush.

---
 rtl/control_sequencer_if.sv | 44 ++++
 rtl/control_sequencer.sv | 162 ++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Instruction-in / decoded-control-out bundle for control_sequencer.
// The master side (the source of instructions) drives instructions, stall and flush; the slave side (the sequencer) returns the decoded strobes and fields.
interface control_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned ACT_W  = 2,
    parameter int unsigned REP_W  = 4,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned INSTR_W = REP_W + 3 + ACT_W + 2 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [INSTR_W-1:0] instr_in;
    logic               instr_valid;
    logic               instr_ready;
    logic               stall;
    logic               flush;
    logic               out_valid;
    logic               nn_start;
    logic               accept_w;
    logic               switch;
    logic               load_weights;
    logic               load_bias;
    logic               load_inputs;
    logic [ACT_W-1:0]   activation_datapath;
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  data_in;
    logic [CNT_W-1:0]   fifo_count;
    logic               busy;

    modport master (
        output instr_in, instr_valid, stall, flush,
        input  instr_ready, out_valid, nn_start, accept_w, switch,
               load_weights, load_bias, load_inputs,
               activation_datapath, address, data_in, fifo_count, busy
    );

    modport slave (
        input  instr_in, instr_valid, stall, flush,
        output instr_ready, out_valid, nn_start, accept_w, switch,
               load_weights, load_bias, load_inputs,
               activation_datapath, address, data_in, fifo_count, busy
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction FIFO plus issue FSM: pops one instruction at a time and holds its
// decoded control strobes for rep+1 non-stalled cycles, with stall and flush.
module control_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned ACT_W  = 2,
    parameter int unsigned REP_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    control_sequencer_if.slave bus
);
    localparam int unsigned INSTR_W  = REP_W + 3 + ACT_W + 2 + ADDR_W + DATA_W;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ADDR_LSB = DATA_W;
    localparam int unsigned SEL_LSB  = ADDR_LSB + ADDR_W;
    localparam int unsigned ACT_LSB  = SEL_LSB + 2;
    localparam int unsigned SW_BIT   = ACT_LSB + ACT_W;
    localparam int unsigned AW_BIT   = SW_BIT + 1;
    localparam int unsigned NS_BIT   = SW_BIT + 2;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state, state_d;
    logic [REP_W-1:0]   rep_cnt, rep_cnt_d;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [INSTR_W-1:0] head;
    logic               empty, push, pop, load_new, issue;
    logic               cur_ns, cur_aw, cur_sw;
    logic [1:0]         cur_sel;
    logic               sel_ns, sel_aw, sel_sw;
    logic [1:0]         sel_sel;

    assign head            = mem[rd_ptr];
    assign empty           = (count == '0);
    assign bus.instr_ready = (count < CNT_W'(DEPTH));
    assign push            = bus.instr_valid && bus.instr_ready && !bus.flush;
    assign bus.fifo_count  = count;
    assign bus.busy        = !empty || bus.out_valid || (state == ACTIVE);

    // Strobe source: freshly popped head, or the held active instruction after a stall.
    assign sel_ns  = load_new ? head[NS_BIT] : cur_ns;
    assign sel_aw  = load_new ? head[AW_BIT] : cur_aw;
    assign sel_sw  = load_new ? head[SW_BIT] : cur_sw;
    assign sel_sel = load_new ? head[SEL_LSB +: 2] : cur_sel;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.instr_in;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_d;
            rep_cnt <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        rep_cnt_d = rep_cnt;
        pop       = 1'b0;
        load_new  = 1'b0;
        issue     = 1'b0;
        if (bus.flush) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && !bus.stall) begin
                        pop       = 1'b1;
                        load_new  = 1'b1;
                        issue     = 1'b1;
                        state_d   = ACTIVE;
                        rep_cnt_d = head[INSTR_W-1 -: REP_W];
                    end
                end
                ACTIVE: begin
                    if (!bus.stall) begin
                        if (rep_cnt != '0) begin
                            rep_cnt_d = rep_cnt - REP_W'(1);
                            issue     = 1'b1;
                        end else if (!empty) begin
                            pop       = 1'b1;
                            load_new  = 1'b1;
                            issue     = 1'b1;
                            rep_cnt_d = head[INSTR_W-1 -: REP_W];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs: strobes follow issue, fields load only on a pop and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid           <= 1'b0;
            bus.nn_start            <= 1'b0;
            bus.accept_w            <= 1'b0;
            bus.switch              <= 1'b0;
            bus.load_weights        <= 1'b0;
            bus.load_bias           <= 1'b0;
            bus.load_inputs         <= 1'b0;
            bus.activation_datapath <= '0;
            bus.address             <= '0;
            bus.data_in             <= '0;
            cur_ns                  <= 1'b0;
            cur_aw                  <= 1'b0;
            cur_sw                  <= 1'b0;
            cur_sel                 <= 2'b00;
        end else begin
            bus.out_valid    <= issue;
            bus.nn_start     <= issue && sel_ns;
            bus.accept_w     <= issue && sel_aw;
            bus.switch       <= issue && sel_sw;
            bus.load_weights <= issue && (sel_sel == 2'b11);
            bus.load_bias    <= issue && (sel_sel == 2'b10);
            bus.load_inputs  <= issue && (sel_sel == 2'b01);
            if (load_new) begin
                bus.activation_datapath <= head[ACT_LSB +: ACT_W];
                bus.address             <= head[ADDR_LSB +: ADDR_W];
                bus.data_in             <= head[DATA_W-1:0];
                cur_ns                  <= head[NS_BIT];
                cur_aw                  <= head[AW_BIT];
                cur_sw                  <= head[SW_BIT];
                cur_sel                 <= head[SEL_LSB +: 2];
            end
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a scoreboard queue holds one expected
// output record per issue cycle and is drained whenever out_valid is seen.
module tb_control_sequencer;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 1;
    localparam int unsigned ACT_W   = 2;
    localparam int unsigned REP_W   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned INSTR_W = REP_W + 3 + ACT_W + 2 + ADDR_W + DATA_W;

    logic clk;
    logic rst;

    control_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACT_W(ACT_W),
                           .REP_W(REP_W), .DEPTH(DEPTH)) bus ();

    control_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACT_W(ACT_W),
                        .REP_W(REP_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    int          cyc, nvalid, nacc, nmulti, first_v, last_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk_word(input logic [REP_W-1:0] rep, input logic ns,
            input logic aw, input logic sw, input logic [ACT_W-1:0] act, input logic [1:0] sel,
            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        return {rep, ns, aw, sw, act, sel, addr, data};
    endfunction

    function automatic logic [31:0] exp_rec(input logic ns, input logic aw, input logic sw,
            input logic [1:0] sel, input logic [ACT_W-1:0] act, input logic [ADDR_W-1:0] addr,
            input logic [DATA_W-1:0] data);
        logic lw, lb, li;
        lw = (sel == 2'b11);
        lb = (sel == 2'b10);
        li = (sel == 2'b01);
        return 32'({ns, aw, sw, lw, lb, li, act, addr, data});
    endfunction

    function automatic logic [31:0] obs_rec();
        return 32'({bus.nn_start, bus.accept_w, bus.switch, bus.load_weights, bus.load_bias,
                    bus.load_inputs, bus.activation_datapath, bus.address, bus.data_in});
    endfunction

    // One clock: sample after the edge and drain or police the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            nvalid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (bus.accept_w === 1'b1) nacc++;
            if ((int'(bus.load_weights) + int'(bus.load_bias) + int'(bus.load_inputs)) > 1) nmulti++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sb_issue", obs_rec(), sb.pop_front());
        end else begin
            check("idle_strobes", 32'({bus.out_valid, bus.nn_start, bus.accept_w, bus.switch,
                  bus.load_weights, bus.load_bias, bus.load_inputs}), 32'd0);
        end
    endtask

    task automatic clear_meas();
        nvalid = 0; nacc = 0; nmulti = 0; first_v = -1; last_v = -1;
    endtask

    task automatic expect_issue(input int rep, input logic [31:0] rec);
        for (int i = 0; i <= rep; i++) sb.push_back(rec);
    endtask

    task automatic send(input logic [INSTR_W-1:0] word);
        logic acc, ok;
        ok = 1'b0;
        bus.instr_in    = word;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = bus.instr_ready;
            tick();
            if (acc) begin ok = 1'b1; break; end
        end
        bus.instr_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.busy === 1'b0) begin done = 1'b1; break; end
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin
        logic [5:0] pat;
        rst = 1'b0;
        bus.instr_in = '0; bus.instr_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        cyc = 0;
        clear_meas();

        // Asynchronous reset asserted mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_fields", 32'({bus.activation_datapath, bus.address, bus.data_in}), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Single issue, load_sel=10, rep=0
        clear_meas();
        expect_issue(0, exp_rec(1'b0, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0, 16'h1234));
        send(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b10, 1'b0, 16'h1234));
        check("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
        check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_load_bias", 32'(bus.load_bias), 32'd1);
        check("t1_data_in", 32'(bus.data_in), 32'h1234);
        tick();
        check("t1_ends", 32'(bus.out_valid), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_field_hold", 32'(bus.data_in), 32'h1234);

        // Repeat: accept_w, rep=3
        clear_meas();
        expect_issue(3, exp_rec(1'b0, 1'b1, 1'b0, 2'b00, 2'd1, 1'b1, 16'h0055));
        send(mk_word(4'd3, 1'b0, 1'b1, 1'b0, 2'd1, 2'b00, 1'b1, 16'h0055));
        wait_idle(40);
        check("t2_accept_cycles", 32'(nacc), 32'd4);
        check("t2_contiguous", 32'(last_v - first_v + 1), 32'd4);
        check("t2_fifo_empty", 32'(bus.fifo_count), 32'd0);

        // Fill while stalled, hold the fifth word, then drain with no bubble
        clear_meas();
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_issue(0, exp_rec(1'b0, 1'b0, 1'b0, 2'b11, 2'(k), 1'b0, 16'(16'h0100 + k)));
            send(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 2'(k), 2'b11, 1'b0, 16'(16'h0100 + k)));
        end
        check("t3_full_ready", 32'(bus.instr_ready), 32'd0);
        check("t3_full_count", 32'(bus.fifo_count), 32'd4);
        expect_issue(0, exp_rec(1'b0, 1'b0, 1'b0, 2'b01, 2'd0, 1'b1, 16'h0104));
        bus.instr_in    = mk_word(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 16'h0104);
        bus.instr_valid = 1'b1;
        tick(); tick();
        check("t3_held_count", 32'(bus.fifo_count), 32'd4);
        check("t3_stalled_idle", 32'(bus.out_valid), 32'd0);
        bus.stall = 1'b0;
        send(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b01, 1'b1, 16'h0104));
        wait_idle(40);
        check("t3_issue_count", 32'(nvalid), 32'd5);
        check("t3_no_bubble", 32'(last_v - first_v + 1), 32'd5);

        // Stall for two cycles after the first issue cycle of a rep=2 instruction
        clear_meas();
        pat = '0;
        expect_issue(2, exp_rec(1'b0, 1'b0, 1'b0, 2'b01, 2'd2, 1'b0, 16'hBEEF));
        send(mk_word(4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 2'b01, 1'b0, 16'hBEEF));
        for (int s = 0; s < 6; s++) begin
            bus.stall = (s == 1 || s == 2);
            tick();
            pat = {pat[4:0], bus.out_valid};
            check("t4_data_const", 32'(bus.data_in), 32'hBEEF);
        end
        check("t4_valid_pattern", 32'(pat), 32'(6'b100110));
        check("t4_busy_end", 32'(bus.busy), 32'd0);

        // Flush with three queued behind an active rep=5, concurrent push dropped
        clear_meas();
        expect_issue(5, exp_rec(1'b0, 1'b0, 1'b0, 2'b10, 2'd3, 1'b1, 16'hA5A5));
        send(mk_word(4'd5, 1'b0, 1'b0, 1'b0, 2'd3, 2'b10, 1'b1, 16'hA5A5));
        tick();
        for (int k = 0; k < 3; k++) begin
            expect_issue(0, exp_rec(1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 16'(16'h0B00 + k)));
            send(mk_word(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 16'(16'h0B00 + k)));
        end
        check("t5_queued", 32'(bus.fifo_count), 32'd3);
        check("t5_active", 32'(bus.out_valid), 32'd1);
        bus.instr_in    = mk_word(4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b11, 1'b0, 16'hDEAD);
        bus.instr_valid = 1'b1;
        bus.flush       = 1'b1;
        tick();
        bus.flush       = 1'b0;
        bus.instr_valid = 1'b0;
        sb.delete();
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_count", 32'(bus.fifo_count), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        tick(); tick(); tick();
        check("t5_word_dropped", 32'(bus.fifo_count), 32'd0);
        check("t5_stays_idle", 32'(nvalid), 32'd4);

        // Decode sweep: every load_sel with nn_start and switch set
        clear_meas();
        for (int k = 0; k < 4; k++) begin
            expect_issue(0, exp_rec(1'b1, 1'b0, 1'b1, 2'(k), 2'(k), 1'(k), 16'(16'hC000 + k)));
            send(mk_word(4'd0, 1'b1, 1'b0, 1'b1, 2'(k), 2'(k), 1'(k), 16'(16'hC000 + k)));
        end
        wait_idle(40);
        check("t6_issue_count", 32'(nvalid), 32'd4);
        check("t6_one_load_max", 32'(nmulti), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
